myproject_mul_rr_arb: RTL
=========================

MYPROJECT_MUL_RR_ARB -- requirements
Module: myproject_mul_rr_arb

Interface
REQ-001 SHALL provide parameter N_REQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 SHALL provide parameter DIN0_WIDTH, default 8, signed operand-A width.
REQ-003 SHALL provide parameter DIN1_WIDTH, default 6, signed operand-B width.
REQ-004 SHALL provide parameter DOUT_WIDTH, default 13, result width.
REQ-005 SHALL provide parameter ID_WIDTH, default 2, requester-index width, with 2**ID_WIDTH >= N_REQ.
REQ-006 Ports, as name  direction  width  meaning:
- ap_clk  in  1  sole clock, rising edge.
- ap_rst  in  1  asynchronous active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_din0  in  N_REQ*DIN0_WIDTH  operand A, requester i at bits [i*DIN0_WIDTH +: DIN0_WIDTH].
- req_din1  in  N_REQ*DIN1_WIDTH  operand B, packed the same way.
- req_ready  out  N_REQ  per-requester accept strobe.
- res_valid  out  1  result register holds a product.
- res_dout  out  DOUT_WIDTH  product.
- res_id  out  ID_WIDTH  index of the originating requester.
- res_ready  in  1  downstream accepts the result.
- res_count  out  16  count of results delivered.
REQ-007 One clock; reset is asynchronous and active-high; the clock port is named ap_clk and the reset port ap_rst.

Function
REQ-008 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1; a result transfer SHALL occur where res_valid and res_ready are both 1.
REQ-009 The block SHALL assert at most one req_ready bit per cycle.
REQ-010 can_accept SHALL be (!res_valid || res_ready); req_ready[i] SHALL be 1 only when can_accept is 1 and i is the grant winner.
REQ-011 req_ready MAY depend combinationally on req_valid and res_ready; req_valid SHALL NOT depend on req_ready.
REQ-012 The grant winner SHALL be the first requester with req_valid set, searching upward from index ptr modulo N_REQ.
REQ-013 After a transfer from requester g, ptr SHALL become (g+1) mod N_REQ; ptr SHALL be unchanged in cycles with no transfer.
REQ-014 The block SHALL compute the full signed product of the winner's $signed(din0) and $signed(din1), and SHALL keep the low DOUT_WIDTH bits; overflow SHALL wrap and SHALL NOT saturate.
REQ-015 On a requester transfer, the block SHALL load the product and winner index into res_dout and res_id at the same edge and SHALL set res_valid to 1, giving a latency of 1 cycle.
REQ-016 Throughput SHALL be 1 result per cycle while res_ready stays 1.
REQ-017 While res_valid=1 and res_ready=0, the block SHALL hold res_dout, res_id and res_valid stable, and req_ready SHALL be all 0.
REQ-018 When a result transfers and no requester transfers in the same cycle, res_valid SHALL clear at the next edge.
REQ-019 When a result transfer and a requester transfer occur in the same cycle, the register SHALL be reloaded with the new product and res_valid SHALL stay 1.
REQ-020 res_count SHALL increment by 1 on each result transfer and SHALL wrap from 0xFFFF to 0x0000.
REQ-021 A requester's valid SHALL be served within N_REQ transfers, which excludes starvation.

Reset
REQ-022 While ap_rst=1, independent of ap_clk, res_valid SHALL be 0, res_dout 0, res_id 0, res_count 0, ptr 0, and req_ready all 0.
REQ-023 Reset asserted mid-operation SHALL discard any held result with no res_valid pulse; the first edge after release SHALL be able to accept a transfer, with requester 0 at highest priority.

Verification
REQ-024 Single product: req_valid=0001, din0[0]=0x05, din1[0]=6'h3D (-3), res_ready=1 -> next cycle res_valid=1, res_dout=13'h1FF1 (-15), res_id=0, and res_count reads 1 after the transfer.
REQ-025 Wrap corner: din0=0x80 (-128), din1=6'h20 (-32) -> res_dout=13'h1000 (-4096, wrapped from +4096); 0x7F*6'h1F -> 13'h0F61 (3937).
REQ-026 Round-robin: all four req_valid held at 1, res_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles, res_id following one cycle later.
REQ-027 Backpressure: res_ready=0 for 3 cycles with one result held -> res_dout and res_id stable and req_ready=0000; res_ready=1 -> simultaneous drain and reload occurs with no bubble.
REQ-028 Reset while res_valid=1 and ptr=2 -> res_valid=0 immediately; after release with req_valid=1111, the first grant goes to requester 0.
REQ-029 Counter wrap: 65536 result transfers -> res_count returns to 0x0000.

Source files
------------

// File: rtl/myproject_mul_rr_arb.sv
// ============================================================================
// Module      : myproject_mul_rr_arb
// Description : Round-robin arbiter feeding one registered signed multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module myproject_mul_rr_arb #(
    parameter int N_REQ      = 4,
    parameter int DIN0_WIDTH = 8,
    parameter int DIN1_WIDTH = 6,
    parameter int DOUT_WIDTH = 13,
    parameter int ID_WIDTH   = 2
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic [N_REQ-1:0]                 req_valid,
    input  logic [N_REQ*DIN0_WIDTH-1:0]      req_din0,
    input  logic [N_REQ*DIN1_WIDTH-1:0]      req_din1,
    output logic [N_REQ-1:0]                 req_ready,
    output logic                             res_valid,
    output logic [DOUT_WIDTH-1:0]            res_dout,
    output logic [ID_WIDTH-1:0]              res_id,
    input  logic                             res_ready,
    output logic [15:0]                      res_count
);

    localparam int c_PROD_W = DIN0_WIDTH + DIN1_WIDTH;
    localparam int c_FULL_W = (c_PROD_W > DOUT_WIDTH) ? c_PROD_W : DOUT_WIDTH;
    localparam logic [ID_WIDTH-1:0] c_LAST = ID_WIDTH'(N_REQ - 1);

    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic                  res_valid_q, res_valid_d;
    logic [DOUT_WIDTH-1:0] res_dout_q, res_dout_d;
    logic [ID_WIDTH-1:0]   res_id_q, res_id_d;
    logic [15:0]           res_count_q, res_count_d;

    logic                  w_can_accept;
    logic                  w_any_lo, w_any_hi, w_grant;
    logic [ID_WIDTH-1:0]   w_win_lo, w_win_hi, w_win;
    logic [DIN0_WIDTH-1:0] w_a;
    logic [DIN1_WIDTH-1:0] w_b;
    logic [c_FULL_W-1:0]   w_a_ext, w_b_ext;
    logic [DOUT_WIDTH-1:0] w_prod;

    // Two priority searches: lowest valid index at/above ptr, else lowest overall.
    always_comb begin
        w_any_lo = 1'b0;
        w_any_hi = 1'b0;
        w_win_lo = '0;
        w_win_hi = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_any_lo = 1'b1;
                w_win_lo = ID_WIDTH'(i);
                if (ID_WIDTH'(i) >= ptr_q) begin
                    w_any_hi = 1'b1;
                    w_win_hi = ID_WIDTH'(i);
                end
            end
        end
        w_win        = w_any_hi ? w_win_hi : w_win_lo;
        w_can_accept = !res_valid_q || res_ready;
        w_grant      = w_any_lo && w_can_accept && !ap_rst;
    end

    always_comb begin
        req_ready = '0;
        w_a       = '0;
        w_b       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = w_grant && (w_win == ID_WIDTH'(i));
            if (w_win == ID_WIDTH'(i)) begin
                w_a = req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
                w_b = req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
            end
        end
    end

    // Sign-extend before multiplying so the low bits are the signed product.
    always_comb begin
        w_a_ext = {{(c_FULL_W - DIN0_WIDTH){w_a[DIN0_WIDTH-1]}}, w_a};
        w_b_ext = {{(c_FULL_W - DIN1_WIDTH){w_b[DIN1_WIDTH-1]}}, w_b};
        w_prod  = DOUT_WIDTH'(w_a_ext * w_b_ext);
    end

    always_comb begin
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        res_dout_d  = res_dout_q;
        res_id_d    = res_id_q;
        res_count_d = res_count_q;
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            res_count_d = res_count_q + 16'd1;
        end
        if (w_grant) begin
            res_valid_d = 1'b1;
            res_dout_d  = w_prod;
            res_id_d    = w_win;
            ptr_d       = (w_win == c_LAST) ? '0 : w_win + ID_WIDTH'(1);
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_dout_q  <= '0;
            res_id_q    <= '0;
            res_count_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_dout_q  <= res_dout_d;
            res_id_q    <= res_id_d;
            res_count_q <= res_count_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_dout  = res_dout_q;
    assign res_id    = res_id_q;
    assign res_count = res_count_q;

endmodule

`default_nettype wire
